vga_object_scheduler: RTL and testbench
=======================================

# vga_object_scheduler

Sits between the VGA sync generator (1024x768 timing, negative syncs) and the DAC/pins. Game logic updates object rectangles (ball, paddles, score) through a req/ack port at any time. Updates are double-buffered and committed once per frame at vertical sync, so the picture never tears. A 2-stage pipeline hit-tests every pixel against all objects, picks a winner by priority, and drives RGB with sync/blank delayed to match.

## Interface
- NUM_OBJ, 4: number of object slots; index 0 has highest priority.
- X_W, 10: xPixel/object X width.
- Y_W, 10: yPixel/object Y width.
- COLOR_W, 24: RGB width (8:8:8).
- BG_COLOR, 24'h000000: colour when no object hits.

- reset  in  1  asynchronous, active-high
- inClock  in  1  pixel clock
- vSyncIn  in  1  from sync generator, active low
- hSyncIn  in  1  from sync generator, active low
- blankIn  in  1  from sync generator, 1 = blanking
- xPixel  in  X_W  current column (0 during blank)
- yPixel  in  Y_W  current row (0 during blank)
- updReq  in  1  update request; held until updAck
- updIdx  in  $clog2(NUM_OBJ)  target slot
- updX, updW  in  X_W  left edge, width (W=0 disables slot)
- updY, updH  in  Y_W  top edge, height (H=0 disables slot)
- updColor  in  COLOR_W  slot colour
- updAck  out  1  one-cycle acknowledge; shadow written that cycle
- frameTick  out  1  one-cycle pulse on commit
- vSyncOut, hSyncOut, blankOut  out  1  inputs delayed 2 cycles
- rgbOut  out  COLOR_W  pixel colour
- hitValid  out  1  some object hit at this output pixel
- hitIdx  out  $clog2(NUM_OBJ)  winning slot (0 when !hitValid)

## Operation
- Two register banks per slot, shadow and active, each holding {X,Y,W,H,color}. Reset clears both banks to 0, so all slots are disabled.
- Update handshake:
  - When updReq=1 in SCAN state and updAck was 0 the previous cycle, the block writes the shadow slot updIdx and asserts updAck for exactly 1 cycle.
  - The requester drops or changes updReq after seeing updAck. The minimum spacing between acks is 2 cycles.
  - updIdx >= NUM_OBJ is acked, but no write occurs.
- FSM states:
  - INIT: entered on reset. No commits occur and rgbOut=BG_COLOR when not blanked. Goes to SCAN on the first vSyncIn falling edge, which also commits.
  - SCAN: normal operation. A vSyncIn falling edge (1→0, detected with a registered previous value) moves to COMMIT.
  - COMMIT: lasts 1 cycle. Copies all shadow slots to active, pulses frameTick, and returns to SCAN. No updAck is issued in this cycle; a pending updReq is acked on the next cycle, and that write lands in the next frame.
- Hit test, stage 1 (registered): hit[i] = (W!=0) && (H!=0) && x>=X && x<X+W && y>=Y && y<Y+H.
  - Sums use X_W+1 / Y_W+1 bits, so there is no wrap. Rectangles past column 1023 or row 767 are clipped naturally.
- Priority select, stage 2 (registered): lowest-index hit wins.
  - rgbOut = 0 when delayed blank=1; otherwise it is the winning colour, or BG_COLOR if there is no hit.
- hitValid is forced to 0 while delayed blank=1.

## Timing
- Pixel pipeline latency is 2 cycles. vSyncOut/hSyncOut/blankOut/rgbOut/hitValid/hitIdx for the pixel at cycle n appear at cycle n+2.
- Reset values: vSyncOut=1, hSyncOut=1, blankOut=1, rgbOut=0, hitValid=0, hitIdx=0, updAck=0, frameTick=0, state=INIT.
- Reset mid-frame clears the pipeline and both banks immediately (asynchronous). Outputs show blank until 2 cycles after reset release.
- frameTick is asserted in the cycle after the vSyncIn falling edge is sampled. Active registers change on that same edge, which is well inside vertical blanking, so no visible pixel uses mixed data.
- A simultaneous vSync edge and updReq resolves to commit first; the ack is delayed 1 cycle.
- An update to slot k acked before the commit cycle is visible on the next frame. An update acked after it is visible one frame later.

## Test plan
- Reset, then the first vSync fall: frameTick=1 for 1 cycle, and every visible pixel is rgbOut=0x000000 with hitValid=0.
- Write slot 1 with X=100, Y=200, W=10, H=5, color=0xFF0000, then wait for commit. Required response:
  - Pixels (100..109, 200..204) give 0xFF0000 with hitIdx=1.
  - (110,200) and (100,205) give background.
  - Every output is 2 cycles after its input pixel.
- Overlap: slot 0 at (50,50,20,20) 0x00FF00 and slot 2 at (60,60,20,20) 0x0000FF. Pixel (65,65) gives 0x00FF00/hitIdx=0, and (75,75) gives 0x0000FF/hitIdx=2.
- Tear-free: write slot 0 X=300 during visible lines. The current frame still shows the old X; after the next frameTick the new X shows. updReq raised on the commit cycle is acked exactly 1 cycle later.
- Clipping/disable: slot 3 with X=1020, W=10 gives hits only at columns 1020..1023 with no wrap to column 0. W=0 gives no hits.
- Reset asserted mid-line: blankOut=1 and rgbOut=0 at once. After release the block waits in INIT, with no objects shown until the next vSync fall.

Source files
------------

// File: rtl/vga_object_scheduler.sv
// Double-buffered object rectangle store with a 2-stage hit-test/priority pixel pipeline.
// Shadow bank takes game-logic updates at any time; active bank is refreshed once per frame at vSync fall.
module vga_object_scheduler #(
    parameter int unsigned NUM_OBJ = 4,
    parameter int unsigned X_W = 10,
    parameter int unsigned Y_W = 10,
    parameter int unsigned COLOR_W = 24,
    parameter logic [COLOR_W-1:0] BG_COLOR = 24'h000000,
    localparam int unsigned IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic               reset,
    input  logic               inClock,
    input  logic               vSyncIn,
    input  logic               hSyncIn,
    input  logic               blankIn,
    input  logic [X_W-1:0]     xPixel,
    input  logic [Y_W-1:0]     yPixel,
    input  logic               updReq,
    input  logic [IDX_W-1:0]   updIdx,
    input  logic [X_W-1:0]     updX,
    input  logic [X_W-1:0]     updW,
    input  logic [Y_W-1:0]     updY,
    input  logic [Y_W-1:0]     updH,
    input  logic [COLOR_W-1:0] updColor,
    output logic               updAck,
    output logic               frameTick,
    output logic               vSyncOut,
    output logic               hSyncOut,
    output logic               blankOut,
    output logic [COLOR_W-1:0] rgbOut,
    output logic               hitValid,
    output logic [IDX_W-1:0]   hitIdx
);

    typedef enum logic [1:0] {
        S_INIT,
        S_SCAN,
        S_COMMIT
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic r_vSyncPrev;
    logic r_ackPrev;
    logic w_vFall;
    logic w_ack;
    logic w_commit;

    logic [X_W-1:0]     r_shX [NUM_OBJ];
    logic [X_W-1:0]     r_shW [NUM_OBJ];
    logic [Y_W-1:0]     r_shY [NUM_OBJ];
    logic [Y_W-1:0]     r_shH [NUM_OBJ];
    logic [COLOR_W-1:0] r_shC [NUM_OBJ];

    logic [X_W-1:0]     r_acX [NUM_OBJ];
    logic [X_W-1:0]     r_acW [NUM_OBJ];
    logic [Y_W-1:0]     r_acY [NUM_OBJ];
    logic [Y_W-1:0]     r_acH [NUM_OBJ];
    logic [COLOR_W-1:0] r_acC [NUM_OBJ];

    logic [NUM_OBJ-1:0] w_hit;
    logic [NUM_OBJ-1:0] r_hit;
    logic               r_vSync1;
    logic               r_hSync1;
    logic               r_blank1;

    logic               w_found;
    logic [IDX_W-1:0]   w_winIdx;
    logic [COLOR_W-1:0] w_winColor;

    assign w_vFall = r_vSyncPrev & ~vSyncIn;

    always_ff @(posedge inClock or posedge reset) begin
        if (reset) begin
            r_state     <= S_INIT;
            r_vSyncPrev <= 1'b1;
            r_ackPrev   <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_vSyncPrev <= vSyncIn;
            r_ackPrev   <= w_ack;
        end
    end

    // Acks are only granted in SCAN, so a shadow write never coincides with the copy cycle.
    always_comb begin
        w_stateNext = r_state;
        w_ack       = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_INIT: begin
                if (w_vFall) w_stateNext = S_COMMIT;
            end
            S_SCAN: begin
                if (updReq && !r_ackPrev) w_ack = 1'b1;
                if (w_vFall) w_stateNext = S_COMMIT;
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_stateNext = S_SCAN;
            end
            default: w_stateNext = S_INIT;
        endcase
    end

    assign updAck    = w_ack;
    assign frameTick = w_commit;

    always_ff @(posedge inClock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                r_shX[i] <= '0;
                r_shW[i] <= '0;
                r_shY[i] <= '0;
                r_shH[i] <= '0;
                r_shC[i] <= '0;
                r_acX[i] <= '0;
                r_acW[i] <= '0;
                r_acY[i] <= '0;
                r_acH[i] <= '0;
                r_acC[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                // Out-of-range indices match no slot, so they are acked without a write.
                if (w_ack && (updIdx == IDX_W'(i))) begin
                    r_shX[i] <= updX;
                    r_shW[i] <= updW;
                    r_shY[i] <= updY;
                    r_shH[i] <= updH;
                    r_shC[i] <= updColor;
                end
                if (w_commit) begin
                    r_acX[i] <= r_shX[i];
                    r_acW[i] <= r_shW[i];
                    r_acY[i] <= r_shY[i];
                    r_acH[i] <= r_shH[i];
                    r_acC[i] <= r_shC[i];
                end
            end
        end
    end

    // One extra bit on the right-edge sums keeps rectangles past the screen edge from wrapping.
    always_comb begin
        w_hit = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            w_hit[i] = (r_state != S_INIT)
                && (r_acW[i] != '0) && (r_acH[i] != '0)
                && (xPixel >= r_acX[i])
                && ({1'b0, xPixel} < ({1'b0, r_acX[i]} + {1'b0, r_acW[i]}))
                && (yPixel >= r_acY[i])
                && ({1'b0, yPixel} < ({1'b0, r_acY[i]} + {1'b0, r_acH[i]}));
        end
    end

    always_ff @(posedge inClock or posedge reset) begin
        if (reset) begin
            r_hit    <= '0;
            r_vSync1 <= 1'b1;
            r_hSync1 <= 1'b1;
            r_blank1 <= 1'b1;
        end else begin
            r_hit    <= w_hit;
            r_vSync1 <= vSyncIn;
            r_hSync1 <= hSyncIn;
            r_blank1 <= blankIn;
        end
    end

    always_comb begin
        w_found    = 1'b0;
        w_winIdx   = '0;
        w_winColor = BG_COLOR;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            if (r_hit[i] && !w_found) begin
                w_found    = 1'b1;
                w_winIdx   = IDX_W'(i);
                w_winColor = r_acC[i];
            end
        end
    end

    always_ff @(posedge inClock or posedge reset) begin
        if (reset) begin
            vSyncOut <= 1'b1;
            hSyncOut <= 1'b1;
            blankOut <= 1'b1;
            rgbOut   <= '0;
            hitValid <= 1'b0;
            hitIdx   <= '0;
        end else begin
            vSyncOut <= r_vSync1;
            hSyncOut <= r_hSync1;
            blankOut <= r_blank1;
            rgbOut   <= r_blank1 ? '0 : w_winColor;
            hitValid <= w_found && !r_blank1;
            hitIdx   <= (w_found && !r_blank1) ? w_winIdx : '0;
        end
    end

endmodule

// File: tb/tb_vga_object_scheduler.sv
// Bench for vga_object_scheduler: pixel expectations go through a due-cycle scoreboard,
// handshake/commit/reset corners are checked directly.
module tb_vga_object_scheduler;

    logic        reset;
    logic        inClock;
    logic        vSyncIn;
    logic        hSyncIn;
    logic        blankIn;
    logic [9:0]  xPixel;
    logic [9:0]  yPixel;
    logic        updReq;
    logic [1:0]  updIdx;
    logic [9:0]  updX;
    logic [9:0]  updW;
    logic [9:0]  updY;
    logic [9:0]  updH;
    logic [23:0] updColor;
    logic        updAck;
    logic        frameTick;
    logic        vSyncOut;
    logic        hSyncOut;
    logic        blankOut;
    logic [23:0] rgbOut;
    logic        hitValid;
    logic [1:0]  hitIdx;

    vga_object_scheduler #(
        .NUM_OBJ (4),
        .X_W     (10),
        .Y_W     (10),
        .COLOR_W (24),
        .BG_COLOR(24'h000000)
    ) dut (
        .reset    (reset),
        .inClock  (inClock),
        .vSyncIn  (vSyncIn),
        .hSyncIn  (hSyncIn),
        .blankIn  (blankIn),
        .xPixel   (xPixel),
        .yPixel   (yPixel),
        .updReq   (updReq),
        .updIdx   (updIdx),
        .updX     (updX),
        .updW     (updW),
        .updY     (updY),
        .updH     (updH),
        .updColor (updColor),
        .updAck   (updAck),
        .frameTick(frameTick),
        .vSyncOut (vSyncOut),
        .hSyncOut (hSyncOut),
        .blankOut (blankOut),
        .rgbOut   (rgbOut),
        .hitValid (hitValid),
        .hitIdx   (hitIdx)
    );

    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] BLUE  = 24'h0000FF;
    localparam logic [23:0] GOLD  = 24'hABCDEF;
    localparam logic [23:0] BG    = 24'h000000;

    typedef struct {
        int          due;
        logic [29:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        logic        hs;
        logic        bl;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
        logic        hv;
        logic [1:0]  idx;
    } vec_t;

    sb_t  sbq[$];
    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    initial inClock = 1'b0;
    always #5 inClock = ~inClock;
    always @(posedge inClock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each pixel expectation comes due two posedges after it was driven.
    always @(negedge inClock) begin
        sb_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            if (e.due < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: output slot missed, due %0d now %0d", e.name, e.due, cyc);
            end else begin
                chk(e.name, {2'b00, vSyncOut, hSyncOut, blankOut, rgbOut, hitValid, hitIdx},
                    {2'b00, e.exp});
            end
        end
    end

    task automatic step();
        @(posedge inClock);
        #1;
    endtask

    task automatic drive(input logic bl, input logic hs, input logic [9:0] x, input logic [9:0] y);
        blankIn = bl;
        hSyncIn = hs;
        xPixel  = bl ? 10'd0 : x;
        yPixel  = bl ? 10'd0 : y;
    endtask

    task automatic expect_pix(input string name, input logic hs, input logic bl,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic [23:0] rgb, input logic hv, input logic [1:0] idx);
        sb_t e;
        drive(bl, hs, x, y);
        e.due  = cyc + 2;
        e.exp  = {vSyncIn, hs, bl, rgb, hv, idx};
        e.name = name;
        sbq.push_back(e);
        step();
    endtask

    task automatic idle(input int n);
        drive(1'b1, 1'b1, 10'd0, 10'd0);
        repeat (n) step();
    endtask

    task automatic vsync_frame(input string tag);
        drive(1'b1, 1'b1, 10'd0, 10'd0);
        vSyncIn = 1'b0;
        @(negedge inClock) chk({tag, " tick before"}, frameTick, 1'b0);
        step();
        @(negedge inClock) chk({tag, " tick"}, frameTick, 1'b1);
        step();
        @(negedge inClock) chk({tag, " tick after"}, frameTick, 1'b0);
        step();
        vSyncIn = 1'b1;
        step();
    endtask

    task automatic set_upd(input logic [1:0] idx, input logic [9:0] x, input logic [9:0] y,
                           input logic [9:0] w, input logic [9:0] h, input logic [23:0] c);
        updIdx   = idx;
        updX     = x;
        updY     = y;
        updW     = w;
        updH     = h;
        updColor = c;
    endtask

    task automatic write_slot(input string tag, input logic [1:0] idx, input logic [9:0] x,
                              input logic [9:0] y, input logic [9:0] w, input logic [9:0] h,
                              input logic [23:0] c);
        int n   = 0;
        bit got = 1'b0;
        set_upd(idx, x, y, w, h, c);
        updReq = 1'b1;
        while (!got && n < 8) begin
            @(negedge inClock);
            if (updAck) got = 1'b1;
            else begin
                step();
                n++;
            end
        end
        chk({tag, " ack"}, got, 1'b1);
        step();
        updReq = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        vSyncIn = 1'b1;
        updReq  = 1'b0;
        set_upd(2'd0, 10'd0, 10'd0, 10'd0, 10'd0, 24'h0);
        drive(1'b0, 1'b0, 10'd100, 10'd200);
        repeat (3) @(posedge inClock);
        @(negedge inClock);
        chk("reset outputs", {vSyncOut, hSyncOut, blankOut, rgbOut, hitValid, hitIdx},
            {1'b1, 1'b1, 1'b1, 24'h0, 1'b0, 2'd0});
        chk("reset ack/tick", {updAck, frameTick}, 2'b00);
        step();
        reset = 1'b0;
        idle(2);

        // INIT: no commits, background only, even with a visible pixel stream.
        expect_pix("init pix", 1'b1, 1'b0, 10'd100, 10'd200, BG, 1'b0, 2'd0);
        @(negedge inClock) chk("init no tick", frameTick, 1'b0);
        step();
        idle(3);
        vsync_frame("first");
        expect_pix("empty pix a", 1'b1, 1'b0, 10'd100, 10'd200, BG, 1'b0, 2'd0);
        expect_pix("empty pix b", 1'b0, 1'b0, 10'd0, 10'd0, BG, 1'b0, 2'd0);
        idle(3);

        write_slot("slot1", 2'd1, 10'd100, 10'd200, 10'd10, 10'd5, RED);
        write_slot("slot0", 2'd0, 10'd50, 10'd50, 10'd20, 10'd20, GREEN);

        // Held request: ack, then a forced idle cycle, then ack again.
        set_upd(2'd2, 10'd60, 10'd60, 10'd20, 10'd20, BLUE);
        updReq = 1'b1;
        @(negedge inClock) chk("held req ack 1", updAck, 1'b1);
        step();
        @(negedge inClock) chk("held req gap", updAck, 1'b0);
        step();
        @(negedge inClock) chk("held req ack 2", updAck, 1'b1);
        step();
        updReq = 1'b0;
        step();

        write_slot("slot3", 2'd3, 10'd1020, 10'd0, 10'd10, 10'd4, GOLD);
        expect_pix("shadow only", 1'b1, 1'b0, 10'd100, 10'd200, BG, 1'b0, 2'd0);
        idle(3);
        vsync_frame("commit1");

        tbl.push_back('{1'b1, 1'b0, 10'd100,  10'd200, RED,   1'b1, 2'd1});
        tbl.push_back('{1'b1, 1'b0, 10'd109,  10'd204, RED,   1'b1, 2'd1});
        tbl.push_back('{1'b0, 1'b0, 10'd105,  10'd202, RED,   1'b1, 2'd1});
        tbl.push_back('{1'b1, 1'b0, 10'd110,  10'd200, BG,    1'b0, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 10'd100,  10'd205, BG,    1'b0, 2'd0});
        tbl.push_back('{1'b0, 1'b0, 10'd99,   10'd200, BG,    1'b0, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 10'd100,  10'd199, BG,    1'b0, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 10'd65,   10'd65,  GREEN, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 10'd75,   10'd75,  BLUE,  1'b1, 2'd2});
        tbl.push_back('{1'b0, 1'b0, 10'd50,   10'd50,  GREEN, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 10'd69,   10'd69,  GREEN, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 10'd70,   10'd70,  BLUE,  1'b1, 2'd2});
        tbl.push_back('{1'b1, 1'b0, 10'd79,   10'd79,  BLUE,  1'b1, 2'd2});
        tbl.push_back('{1'b0, 1'b0, 10'd80,   10'd80,  BG,    1'b0, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 10'd1020, 10'd0,   GOLD,  1'b1, 2'd3});
        tbl.push_back('{1'b1, 1'b0, 10'd1023, 10'd3,   GOLD,  1'b1, 2'd3});
        tbl.push_back('{1'b1, 1'b0, 10'd1019, 10'd0,   BG,    1'b0, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 10'd0,    10'd0,   BG,    1'b0, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 10'd5,    10'd1,   BG,    1'b0, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 10'd1023, 10'd4,   BG,    1'b0, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 10'd100,  10'd200, BG,    1'b0, 2'd0});
        tbl.push_back('{1'b1, 1'b1, 10'd65,   10'd65,  BG,    1'b0, 2'd0});
        foreach (tbl[i])
            expect_pix($sformatf("vec%0d", i), tbl[i].hs, tbl[i].bl, tbl[i].x, tbl[i].y,
                       tbl[i].rgb, tbl[i].hv, tbl[i].idx);
        idle(3);

        // Tear-free: a mid-frame move only shows after the next commit.
        write_slot("move0", 2'd0, 10'd300, 10'd50, 10'd20, 10'd20, GREEN);
        expect_pix("old pos kept", 1'b1, 1'b0, 10'd55, 10'd55, GREEN, 1'b1, 2'd0);
        expect_pix("new pos not yet", 1'b1, 1'b0, 10'd305, 10'd55, BG, 1'b0, 2'd0);
        idle(3);
        vsync_frame("commit2");
        expect_pix("new pos shown", 1'b1, 1'b0, 10'd305, 10'd55, GREEN, 1'b1, 2'd0);
        expect_pix("old pos gone", 1'b1, 1'b0, 10'd55, 10'd55, BG, 1'b0, 2'd0);
        idle(3);

        // Request raised in the commit cycle: acked one cycle later, lands a frame later.
        drive(1'b1, 1'b1, 10'd0, 10'd0);
        set_upd(2'd1, 10'd400, 10'd200, 10'd10, 10'd5, RED);
        vSyncIn = 1'b0;
        @(negedge inClock) chk("cc fall no tick", frameTick, 1'b0);
        step();
        updReq = 1'b1;
        @(negedge inClock);
        chk("cc tick", frameTick, 1'b1);
        chk("cc no ack in commit", updAck, 1'b0);
        step();
        @(negedge inClock) chk("cc ack next cycle", updAck, 1'b1);
        step();
        updReq  = 1'b0;
        vSyncIn = 1'b1;
        step();
        expect_pix("late write hidden", 1'b1, 1'b0, 10'd405, 10'd200, BG, 1'b0, 2'd0);
        expect_pix("late old kept", 1'b1, 1'b0, 10'd100, 10'd200, RED, 1'b1, 2'd1);
        idle(3);
        vsync_frame("commit3");
        expect_pix("late write shown", 1'b1, 1'b0, 10'd405, 10'd200, RED, 1'b1, 2'd1);
        expect_pix("late old gone", 1'b1, 1'b0, 10'd100, 10'd200, BG, 1'b0, 2'd0);
        idle(3);

        write_slot("disable3", 2'd3, 10'd1020, 10'd0, 10'd0, 10'd4, GOLD);
        vsync_frame("commit4");
        expect_pix("w0 off a", 1'b1, 1'b0, 10'd1020, 10'd0, BG, 1'b0, 2'd0);
        expect_pix("w0 off b", 1'b1, 1'b0, 10'd1023, 10'd3, BG, 1'b0, 2'd0);
        idle(3);

        // Asynchronous reset in the middle of a visible line.
        drive(1'b0, 1'b0, 10'd305, 10'd55);
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        chk("async reset out", {vSyncOut, hSyncOut, blankOut, rgbOut, hitValid, hitIdx},
            {1'b1, 1'b1, 1'b1, 24'h0, 1'b0, 2'd0});
        step();
        step();
        reset = 1'b0;
        expect_pix("post reset pix", 1'b0, 1'b0, 10'd305, 10'd55, BG, 1'b0, 2'd0);
        @(negedge inClock) chk("blank held after release", blankOut, 1'b1);
        step();
        expect_pix("init after reset", 1'b1, 1'b0, 10'd305, 10'd55, BG, 1'b0, 2'd0);
        idle(3);
        vsync_frame("reset commit");
        expect_pix("banks cleared a", 1'b1, 1'b0, 10'd305, 10'd55, BG, 1'b0, 2'd0);
        expect_pix("banks cleared b", 1'b1, 1'b0, 10'd405, 10'd200, BG, 1'b0, 2'd0);
        idle(4);

        chk("scoreboard drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
